// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: operation encodings,
// default latencies and the busy-counter width.
package md_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } md_state_e;

  localparam int MD_MULT_CYCLES_DEF = 5;
  localparam int MD_DIV_CYCLES_DEF  = 10;
  localparam int MD_CNT_W           = 4;

  // MULT/MULTU/DIV/DIVU occupy the unit; MT* and reserved codes do not.
  function automatic logic md_is_arith(input logic [2:0] op);
    return op <= MD_DIVU;
  endfunction

endpackage

// File: rtl/md_div_core.sv
// Combinational 32-bit divider: signed or unsigned quotient/remainder,
// with divide-by-zero flagged and the signed overflow case pinned.
module md_div_core
  import md_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        is_signed,
  output logic [31:0] quo,
  output logic [31:0] rem,
  output logic        div_zero
);

  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] b_safe;
  logic [31:0] q_mag;
  logic [31:0] r_mag;

  // Divide magnitudes, then restore signs: quotient truncates toward zero,
  // remainder takes the sign of the dividend.
  always_comb begin
    div_zero = (b == 32'd0);
    a_neg    = is_signed & a[31];
    b_neg    = is_signed & b[31];
    a_mag    = a_neg ? (32'd0 - a) : a;
    b_mag    = b_neg ? (32'd0 - b) : b;
    b_safe   = div_zero ? 32'd1 : b_mag;
    q_mag    = a_mag / b_safe;
    r_mag    = a_mag % b_safe;
    quo      = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    rem      = a_neg ? (32'd0 - r_mag) : r_mag;

    if (div_zero) begin
      quo = 32'd0;
      rem = 32'd0;
    end else if (is_signed && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      quo = 32'h8000_0000;
      rem = 32'd0;
    end
  end

endmodule

// File: rtl/md_unit.sv
// Multi-cycle MULT/DIV unit owning HI/LO. A down-counter models the fixed
// latency; the result is computed at issue and committed when it expires.
//
//   state   | meaning
//   ST_IDLE | count == 0, accepts MULT/DIV/MT* issue
//   ST_RUN  | count != 0, operation in flight, new starts ignored
module md_unit
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        kill,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [MD_CNT_W-1:0] MULT_LOAD = MD_CNT_W'(MULT_CYCLES);
  localparam logic [MD_CNT_W-1:0] DIV_LOAD  = MD_CNT_W'(DIV_CYCLES);

  logic [MD_CNT_W-1:0] cnt_q,     cnt_d;
  logic [31:0]         pend_hi_q, pend_hi_d;
  logic [31:0]         pend_lo_q, pend_lo_d;
  logic                pend_wr_q, pend_wr_d;
  logic [31:0]         hi_q,      hi_d;
  logic [31:0]         lo_q,      lo_d;
  md_state_e           state;

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] div_quo;
  logic [31:0] div_rem;
  logic        div_zero;

  // 64-bit products of sign/zero-extended operands; the low 64 bits of the
  // extended multiply are the exact signed/unsigned result.
  assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
  assign prod_u = {32'd0, A} * {32'd0, B};

  md_div_core u_div_core (
    .a         (A),
    .b         (B),
    .is_signed (md_op == MD_DIV),
    .quo       (div_quo),
    .rem       (div_rem),
    .div_zero  (div_zero)
  );

  always_comb begin
    cnt_d     = cnt_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    state     = (cnt_q != '0) ? ST_RUN : ST_IDLE;

    case (state)
      ST_IDLE: begin
        if (start) begin
          case (md_op)
            MD_MULT: begin
              {pend_hi_d, pend_lo_d} = prod_s;
              pend_wr_d = 1'b1;
              cnt_d     = MULT_LOAD;
            end
            MD_MULTU: begin
              {pend_hi_d, pend_lo_d} = prod_u;
              pend_wr_d = 1'b1;
              cnt_d     = MULT_LOAD;
            end
            MD_DIV, MD_DIVU: begin
              pend_hi_d = div_rem;
              pend_lo_d = div_quo;
              pend_wr_d = ~div_zero;
              cnt_d     = DIV_LOAD;
            end
            MD_MTHI: hi_d = A;
            MD_MTLO: lo_d = A;
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        // kill wins over a completion on the same edge
        if (kill) begin
          cnt_d     = '0;
          pend_hi_d = '0;
          pend_lo_d = '0;
          pend_wr_d = 1'b0;
        end else begin
          cnt_d = cnt_q - MD_CNT_W'(1);
          if (cnt_q == MD_CNT_W'(1) && pend_wr_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q     <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_wr_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      cnt_q     <= cnt_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy     = (cnt_q != '0);
  assign md_stall = busy | (start & md_is_arith(md_op));
  assign HI       = hi_q;
  assign LO       = lo_q;

endmodule

// File: doc/md_unit.md
# md_unit

Multiply/divide unit for the five-stage MIPS pipeline. It consumes the forwarded register operands that the ID operand-forwarding multiplexers produce, staged through to EX. It runs MULT/MULTU/DIV/DIVU with a fixed multi-cycle latency and owns the architectural HI/LO registers. It exports a busy indication so the hazard unit can stall HI/LO-dependent instructions.

## Interface
Parameters:
- MULT_CYCLES, 5, busy duration for MULT/MULTU (1..15)
- DIV_CYCLES, 10, busy duration for DIV/DIVU (1..15)

Ports:
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  synchronous, active-low; reset==0 at a rising edge clears all state
- start  input  1  issue strobe, one cycle per instruction
- md_op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6–7 reserved (no-op)
- A  input  32  rs operand (forwarded value)
- B  input  32  rt operand (forwarded value)
- kill  input  1  abort the in-flight operation (EX flush)
- busy  output  1  operation in flight
- md_stall  output  1  busy | (start & md_op<=3); hazard unit stalls MFHI/MFLO/MT*/mult-div in ID when high
- HI  output  32  architectural HI register
- LO  output  32  architectural LO register

## Operation
- Reset: HI=0, LO=0, count=0, busy=0, pending result registers=0.
- Idle, start=1, md_op 0–3: latch op, A, B; compute 64-bit result into pending registers; load count with MULT_CYCLES or DIV_CYCLES.
- MULT: {HI,LO}=signed A*B. MULTU: unsigned product.
- DIV: LO=A/B, truncated toward zero; HI=remainder, with the sign of the dividend. DIVU: unsigned.
- B==0 on DIV/DIVU: the op runs its full latency; HI/LO are left unchanged at completion.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- MTHI/MTLO with start=1, not busy: write A to HI or LO at that edge; busy stays 0.
- Reserved md_op: no effect.
- start while busy: ignored. It is a hazard-unit error; the bench flags it, but the RTL must not corrupt state.
- kill=1 while busy: count cleared at that edge; pending result discarded; HI/LO keep their old values.
- kill with start in the same cycle, not busy: start is honoured; kill applies only to an already in-flight op.
- Completion: on the edge where count goes 1→0, write pending HI/LO into HI/LO, unless kill is also high at that edge (kill wins).

## Timing
- The start edge is E0.
- busy=1 during cycles 1..N, where N is the latency parameter.
- The HI/LO write occurs at edge E_N; new values are visible in cycle N+1, the same cycle busy drops.
- A back-to-back start may be issued in cycle N+1.
- MTHI/MTLO: value visible in the cycle after the start edge; zero busy cycles.
- busy is a pure function of count (count!=0), registered with no combinational path from inputs.
- md_stall has a combinational path from start/md_op.
- Reset mid-operation: all state cleared at that edge; busy=0 the next cycle.
- Reset has priority over kill, start and completion.

## Structure
- Shared package md_pkg holds:
  - md_op encodings: MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO
  - default latencies
  - a 4-bit count width constant
- One sub-module, md_div_core: purely combinational signed/unsigned quotient and remainder, including the special cases, so that it is unit-testable in isolation.
- Multiplication is inline.
- Top level contains: latch/pending registers, the count FSM (IDLE when count==0, RUN otherwise), and HI/LO.

## Test plan
- Reset then MULT A=0xFFFFFFFF, B=2 → busy high cycles 1–5; cycle 6: HI=0xFFFFFFFF, LO=0xFFFFFFFE, busy=0.
- MULTU same operands → HI=0x00000001, LO=0xFFFFFFFE after 5 cycles.
- DIV A=0xFFFFFFF9 (−7), B=2 → busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU A=7, B=0 with prior HI=0x11, LO=0x22 → after 10 cycles HI=0x11, LO=0x22 unchanged.
- MULT 3*4 issued, kill at cycle 3 → busy=0 at cycle 4; HI/LO keep old values. Then MTLO A=0x55 → LO=0x55 the next cycle, busy stays 0.
- DIV in flight, reset=0 at cycle 4 → cycle 5: busy=0, HI=LO=0. A second start asserted at cycle 2 of a MULT is ignored: the MULT result alone lands at cycle 6.
